msu_audio_streamer: RTL

- Parametrised successor to the single-channel MSU audio sector fetcher.
- Streams a mounted PCM track from SD (HPS sector interface) into the audio FIFO, one sector at a time, with FIFO back-pressure.
- Handles partial final sectors and play-once/repeat modes, with loop points at any sample (not only sector 0).
- Sits between the MSU register block (trigger, repeat, loop index, image size) and the audio FIFO feeding the DAC mixer.

---
 rtl/msu_audio_streamer.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/msu_audio_streamer.sv
// Streams a mounted MSU PCM track from SD sectors into the audio FIFO with back-pressure,
// partial last sector, play-once/repeat and sample-accurate loop points.
module msu_audio_streamer #(
  parameter int WORD_W           = 16,
  parameter int SECT_WLOG2       = 8,
  parameter int LBA_W            = 21,
  parameter int USEDW_W          = 11,
  parameter int FIFO_HIGH        = 1792,
  parameter int WORDS_PER_SAMPLE = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               trig_play,
  input  logic               stop,
  input  logic               repeat_in,
  input  logic               mount_done,
  input  logic [63:0]        img_size,
  input  logic [31:0]        loop_index,
  output logic [LBA_W-1:0]   sd_lba,
  output logic               sd_rd,
  input  logic               sd_ack,
  input  logic               sd_buff_wr,
  input  logic [WORD_W-1:0]  sd_buff_dout,
  input  logic [USEDW_W-1:0] fifo_usedw,
  output logic               fifo_wr,
  output logic [WORD_W-1:0]  fifo_data,
  output logic               playing,
  output logic               looped,
  output logic               ended
);
  localparam int IDX_W   = SECT_WLOG2 + 1;
  localparam int ADDR_HI = LBA_W + SECT_WLOG2;
  localparam int HW      = USEDW_W + 1;
  localparam logic [IDX_W-1:0] FULL_SECT = {1'b1, {SECT_WLOG2{1'b0}}};
  localparam logic [HW-1:0]    HIGH_MARK = HW'(FIFO_HIGH);

  typedef enum logic [2:0] {
    S_IDLE, S_MOUNT, S_REQ, S_XFER, S_NEXT, S_THROTTLE, S_DRAIN
  } state_t;

  state_t state_reg, state_next;

  // Track geometry decoded from the live register-block inputs; latched on trig_play.
  logic [62:0]           total_words;
  logic [62:0]           total_words_m1;
  logic [63:0]           loop_word_raw;
  logic [63:0]           loop_word;
  logic                  tiny_img;
  logic [LBA_W-1:0]      end_lba_cfg;
  logic [LBA_W-1:0]      loop_lba_cfg;
  logic [IDX_W-1:0]      last_limit_cfg;
  logic [SECT_WLOG2-1:0] loop_skip_cfg;

  always_comb begin
    total_words    = img_size[63:1];
    total_words_m1 = total_words - 63'd1;
    end_lba_cfg    = total_words_m1[ADDR_HI-1:SECT_WLOG2];
    if (total_words[SECT_WLOG2-1:0] == '0) last_limit_cfg = FULL_SECT;
    else                                   last_limit_cfg = {1'b0, total_words[SECT_WLOG2-1:0]};
    loop_word_raw  = 64'(loop_index) * 64'(WORDS_PER_SAMPLE);
    loop_word      = (loop_word_raw >= {1'b0, total_words}) ? 64'd0 : loop_word_raw;
    loop_lba_cfg   = loop_word[ADDR_HI-1:SECT_WLOG2];
    loop_skip_cfg  = loop_word[SECT_WLOG2-1:0];
    tiny_img       = (img_size < 64'd2);
  end

  logic unused_bits;
  assign unused_bits = ^{img_size[0], total_words_m1[62:ADDR_HI], loop_word[63:ADDR_HI]};

  logic [LBA_W-1:0]      end_lba_reg, loop_lba_reg;
  logic [IDX_W-1:0]      last_limit_reg;
  logic [SECT_WLOG2-1:0] loop_skip_reg;
  logic                  repeat_reg;
  logic                  load_cfg;

  logic [LBA_W-1:0]      cur_reg, cur_next;
  logic [SECT_WLOG2-1:0] skip_reg, skip_next;
  logic [IDX_W-1:0]      word_idx_reg, word_idx_next;
  logic                  drain_mount_reg, drain_mount_next;
  logic                  playing_reg, playing_next;
  logic                  looped_reg, looped_next;
  logic                  ended_reg, ended_next;
  logic                  fifo_wr_reg, fifo_wr_next;
  logic [WORD_W-1:0]     fifo_data_reg, fifo_data_next;

  logic [IDX_W-1:0] limit;
  logic             in_window;

  assign limit     = (cur_reg == end_lba_reg) ? last_limit_reg : FULL_SECT;
  assign in_window = ({1'b0, skip_reg} <= word_idx_reg) && (word_idx_reg < limit);

  always_comb begin
    state_next       = state_reg;
    cur_next         = cur_reg;
    skip_next        = skip_reg;
    word_idx_next    = word_idx_reg;
    drain_mount_next = drain_mount_reg;
    playing_next     = playing_reg;
    looped_next      = 1'b0;
    ended_next       = 1'b0;
    fifo_wr_next     = 1'b0;
    fifo_data_next   = fifo_data_reg;
    load_cfg         = 1'b0;
    sd_rd            = (state_reg == S_REQ);

    if (trig_play) begin
      load_cfg     = 1'b1;
      cur_next     = '0;
      skip_next    = '0;
      playing_next = 1'b0;
      if (tiny_img) begin
        ended_next       = 1'b1;
        drain_mount_next = 1'b0;
        state_next       = (state_reg != S_IDLE && sd_ack) ? S_DRAIN : S_IDLE;
      end else if (state_reg != S_IDLE && sd_ack) begin
        // A sector is still in flight: let SD finish it before remounting.
        drain_mount_next = 1'b1;
        state_next       = S_DRAIN;
      end else begin
        state_next = S_MOUNT;
      end
    end else if (stop && state_reg != S_IDLE) begin
      playing_next = 1'b0;
      if (state_reg == S_XFER || state_reg == S_DRAIN || (state_reg == S_REQ && sd_ack)) begin
        drain_mount_next = 1'b0;
        state_next       = S_DRAIN;
      end else begin
        state_next = S_IDLE;
      end
    end else begin
      case (state_reg)
        S_MOUNT: if (mount_done) begin
          playing_next = 1'b1;
          state_next   = S_REQ;
        end
        S_REQ: if (sd_ack) begin
          word_idx_next = '0;
          state_next    = S_XFER;
        end
        S_XFER: begin
          if (!sd_ack) begin
            state_next = S_NEXT;
          end else if (sd_buff_wr) begin
            if (in_window) begin
              fifo_wr_next   = 1'b1;
              fifo_data_next = sd_buff_dout;
            end
            if (word_idx_reg != FULL_SECT) word_idx_next = word_idx_reg + IDX_W'(1);
          end
        end
        S_NEXT: begin
          if (cur_reg < end_lba_reg) begin
            cur_next   = cur_reg + LBA_W'(1);
            skip_next  = '0;
            state_next = S_THROTTLE;
          end else if (repeat_reg) begin
            cur_next    = loop_lba_reg;
            skip_next   = loop_skip_reg;
            looped_next = 1'b1;
            state_next  = S_THROTTLE;
          end else begin
            ended_next   = 1'b1;
            playing_next = 1'b0;
            state_next   = S_IDLE;
          end
        end
        S_THROTTLE: if ({1'b0, fifo_usedw} < HIGH_MARK) state_next = S_REQ;
        S_DRAIN: if (!sd_ack) begin
          state_next       = drain_mount_reg ? S_MOUNT : S_IDLE;
          drain_mount_next = 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= S_IDLE;
      cur_reg         <= '0;
      skip_reg        <= '0;
      word_idx_reg    <= '0;
      drain_mount_reg <= 1'b0;
      playing_reg     <= 1'b0;
      looped_reg      <= 1'b0;
      ended_reg       <= 1'b0;
      fifo_wr_reg     <= 1'b0;
      fifo_data_reg   <= '0;
      end_lba_reg     <= '0;
      loop_lba_reg    <= '0;
      last_limit_reg  <= '0;
      loop_skip_reg   <= '0;
      repeat_reg      <= 1'b0;
    end else begin
      state_reg       <= state_next;
      cur_reg         <= cur_next;
      skip_reg        <= skip_next;
      word_idx_reg    <= word_idx_next;
      drain_mount_reg <= drain_mount_next;
      playing_reg     <= playing_next;
      looped_reg      <= looped_next;
      ended_reg       <= ended_next;
      fifo_wr_reg     <= fifo_wr_next;
      fifo_data_reg   <= fifo_data_next;
      if (load_cfg) begin
        end_lba_reg    <= end_lba_cfg;
        loop_lba_reg   <= loop_lba_cfg;
        last_limit_reg <= last_limit_cfg;
        loop_skip_reg  <= loop_skip_cfg;
        repeat_reg     <= repeat_in;
      end
    end
  end

  assign sd_lba    = cur_reg;
  assign fifo_wr   = fifo_wr_reg;
  assign fifo_data = fifo_data_reg;
  assign playing   = playing_reg;
  assign looped    = looped_reg;
  assign ended     = ended_reg;
endmodule
